// File: rtl/mo_line_sequencer.sv
// Ping-pong line-buffer address sequencer: swaps buffers per line, loads object X, streams OBJ_WIDTH pixel slots.
// Registered outputs, 1 ce5 cycle latency; requester waits on obj_ready. Optional sticky overflow flag: MO_OVERFLOW_FLAG_EN.
module mo_line_sequencer #(
  parameter int MAX_OBJS  = 8,
  parameter int OBJ_WIDTH = 16,
  localparam int IW = $clog2(OBJ_WIDTH)
) (
  input  logic          clk,
  input  logic          reset_n,
  input  logic          ce5,
  input  logic          line_start,
  input  logic          obj_valid,
  input  logic [7:0]    obj_x,
  output logic          obj_ready,
  output logic [7:0]    x_load,
  output logic          ld1_n,
  output logic          ld2_n,
  output logic          cl1_n,
  output logic          cl2_n,
  output logic          wr_sel,
  output logic          pix_we,
  output logic [IW-1:0] pix_idx,
  output logic          busy,
  output logic          overflow
);

  typedef enum logic [2:0] {S_IDLE, S_FETCH, S_LOAD, S_DRAW, S_DONE} state_t;

  localparam logic [IW-1:0] LAST_IDX = IW'(OBJ_WIDTH - 1);
  localparam logic [3:0]    MAX_CNT  = 4'(MAX_OBJS);

  state_t          state_q, state_d;
  logic [3:0]      obj_cnt_q, obj_cnt_d, obj_cnt_inc;
  logic            rdy_d, ld1_d, ld2_d, cl1_d, cl2_d, ws_d, we_d, busy_d;
  logic [7:0]      x_d;
  logic [IW-1:0]   idx_d;

  assign obj_cnt_inc = (obj_cnt_q == MAX_CNT) ? obj_cnt_q : obj_cnt_q + 4'd1;

  always_comb begin
    state_d   = state_q;
    obj_cnt_d = obj_cnt_q;
    rdy_d     = obj_ready;
    x_d       = x_load;
    ld1_d     = 1'b1;
    ld2_d     = 1'b1;
    cl1_d     = 1'b1;
    cl2_d     = 1'b1;
    ws_d      = wr_sel;
    we_d      = pix_we;
    idx_d     = pix_idx;
    if (line_start) begin
      // clear strobe goes to the buffer that becomes the display side
      ws_d      = ~wr_sel;
      cl1_d     = wr_sel;
      cl2_d     = ~wr_sel;
      obj_cnt_d = 4'd0;
      we_d      = 1'b0;
      rdy_d     = 1'b0;
      state_d   = S_FETCH;
    end else begin
      case (state_q)
        S_IDLE: rdy_d = 1'b0;
        S_FETCH: begin
          rdy_d = 1'b1;
          if (obj_valid && obj_ready) begin
            x_d     = obj_x;
            rdy_d   = 1'b0;
            state_d = S_LOAD;
          end
        end
        S_LOAD: begin
          ld1_d   = wr_sel;
          ld2_d   = ~wr_sel;
          idx_d   = '0;
          state_d = S_DRAW;
        end
        S_DRAW: begin
          // first DRAW cycle waits for the counter load to land
          if (!pix_we) begin
            we_d = 1'b1;
          end else if (pix_idx == LAST_IDX) begin
            we_d      = 1'b0;
            obj_cnt_d = obj_cnt_inc;
            if (obj_cnt_inc == MAX_CNT) begin
              state_d = S_DONE;
              rdy_d   = 1'b0;
            end else begin
              state_d = S_FETCH;
              rdy_d   = 1'b1;
            end
          end else begin
            idx_d = pix_idx + 1'b1;
          end
        end
        S_DONE: rdy_d = 1'b0;
        default: begin
          state_d = S_IDLE;
          rdy_d   = 1'b0;
        end
      endcase
    end
    busy_d = (state_d == S_FETCH) || (state_d == S_LOAD) || (state_d == S_DRAW);
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q   <= S_IDLE;
      obj_cnt_q <= 4'd0;
      obj_ready <= 1'b0;
      x_load    <= 8'd0;
      ld1_n     <= 1'b1;
      ld2_n     <= 1'b1;
      cl1_n     <= 1'b1;
      cl2_n     <= 1'b1;
      wr_sel    <= 1'b0;
      pix_we    <= 1'b0;
      pix_idx   <= '0;
      busy      <= 1'b0;
    end else if (ce5) begin
      state_q   <= state_d;
      obj_cnt_q <= obj_cnt_d;
      obj_ready <= rdy_d;
      x_load    <= x_d;
      ld1_n     <= ld1_d;
      ld2_n     <= ld2_d;
      cl1_n     <= cl1_d;
      cl2_n     <= cl2_d;
      wr_sel    <= ws_d;
      pix_we    <= we_d;
      pix_idx   <= idx_d;
      busy      <= busy_d;
    end
  end

`ifdef MO_OVERFLOW_FLAG_EN
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      overflow <= 1'b0;
    end else if (ce5) begin
      if (line_start)
        overflow <= 1'b0;
      else if (state_q == S_DONE && obj_valid)
        overflow <= 1'b1;
    end
  end
`else
  assign overflow = 1'b0;
`endif

endmodule

// File: doc/mo_line_sequencer.md
# mo_line_sequencer

Sequences the motion-object horizontal address counters for the two ping-pong line buffers. Each scanline it swaps the write and display roles of buffer 1 and buffer 2. It clears the display-side counter, and for each object it accepts it loads the object X into the write-side counter, then streams the object's pixel slots. It sits between the object fetch logic (object requester) and the horizontal address counters. It drives their active-low load/clear strobes and the X byte that feeds the counters' load input (SR[15:8]).

## Interface
- MAX_OBJS, 8: objects accepted per scanline (1..15)
- OBJ_WIDTH, 16: pixel slots per object (power of two, 2..16)

- clk  in  1  system clock
- reset_n  in  1  asynchronous, active-low reset
- ce5  in  1  pixel clock enable; all state and outputs advance only on clk edges with ce5=1
- line_start  in  1  start-of-scanline pulse, sampled on ce5
- obj_valid  in  1  requester has an object
- obj_x  in  8  object horizontal position
- obj_ready  out  1  sequencer accepts an object this ce5 cycle
- x_load  out  8  X byte driven to the counters' load input
- ld1_n, ld2_n  out  1 each  load strobes for counter 1 and counter 2
- cl1_n, cl2_n  out  1 each  clear strobes for counter 1 and counter 2
- wr_sel  out  1  write-side buffer: 0 = buffer 1, 1 = buffer 2
- pix_we  out  1  pixel write enable for the write-side buffer
- pix_idx  out  log2(OBJ_WIDTH)  pixel slot within the current object
- busy  out  1  high outside IDLE/DONE
- overflow  out  1  requester had an object after the per-line limit (see Configuration)

## Operation
- All outputs are registered. Reset values: ld*_n=1, cl*_n=1, wr_sel=0, pix_we=0, pix_idx=0, x_load=0, obj_ready=0, busy=0, overflow=0. State is IDLE and obj_cnt=0.
- States: IDLE, FETCH, LOAD, DRAW, DONE.
- line_start (any state):
  - toggle wr_sel
  - pulse the display-side cl*_n low for one ce5 cycle (cl2_n if the new wr_sel=0, cl1_n if it is 1)
  - obj_cnt=0, pix_we=0
  - go to FETCH
  - any object in LOAD/DRAW is abandoned
- The write-side cl*_n is never asserted. The display-side counter free-runs after its clear.
- FETCH: obj_ready=1.
  - On a ce5 cycle with obj_valid&obj_ready: latch obj_x into x_load, drop obj_ready, go to LOAD.
- LOAD: assert the write-side ld*_n low for exactly one ce5 cycle (ld1_n if wr_sel=0). Go to DRAW with pix_idx=0.
- DRAW: pix_we=1. pix_idx increments each ce5 cycle.
  - At pix_idx=OBJ_WIDTH-1: increment obj_cnt (4-bit, saturating at MAX_OBJS) and clear pix_we.
  - Then go to DONE if obj_cnt==MAX_OBJS, else FETCH.
- DONE: hold until line_start. obj_ready=0.
- The counter address wraps 255→0 naturally. The sequencer does not clip objects at the right edge.
- line_start coincident with an obj_valid&obj_ready acceptance: line_start wins and the object is not consumed. The requester must re-present it.

## Timing
- line_start sampled at ce5 edge N:
  - wr_sel toggles and the display cl*_n is low after edge N
  - the counter clears at edge N+1
  - obj_ready is high after edge N+1
- Acceptance at edge A:
  - ld*_n is low after A+1; the counter loads at A+2
  - pix_we/pix_idx=0 are valid after A+2
  - the last slot is after A+OBJ_WIDTH+1
  - obj_ready is high again after A+OBJ_WIDTH+2
- Per object: OBJ_WIDTH+2 ce5 cycles plus requester wait.
- ce5 low: all outputs and state hold. The handshake is not evaluated.
- reset_n low mid-line: immediate return to reset values. No strobes are issued until the next line_start.

## Configuration
- MO_OVERFLOW_FLAG_EN defined:
  - overflow sets (sticky) on any ce5 cycle in DONE with obj_valid=1
  - it clears at line_start
- Not defined: overflow is constant 0 and no extra logic is built. The port remains.

## Test plan
- Reset then line_start: wr_sel=1, cl1_n low for one ce5 cycle, cl2_n/ld*_n stay 1, obj_ready high two ce5 cycles after line_start.
- One object obj_x=0x40, wr_sel=0: ld1_n low for one cycle with x_load=0x40, then 16 cycles of pix_we=1 with pix_idx 0..15, counter 1 sequence 0x40..0x4F.
- obj_x=0xF8, OBJ_WIDTH=16: counter wraps 0xFF→0x00 mid-object, pix_we stays high all 16 slots.
- Requester holds obj_valid=1 for 10 objects, MAX_OBJS=8: exactly 8 acceptances, state DONE. With MO_OVERFLOW_FLAG_EN, overflow=1 until the next line_start; without it, overflow=0.
- line_start during DRAW at pix_idx=5: pix_we drops after that edge, wr_sel toggles, the display clear pulses, the interrupted object is not counted, FETCH resumes.
- ce5 duty 1/4 with reset_n asserted mid-DRAW: outputs hold between enables, and reset immediately restores all reset values.
